// File: rtl/mac_dot_pkg.sv
// rtl/mac_dot_pkg.sv - shared constants and FSM encoding for the MAC dot-product sequencer
package mac_dot_pkg;

  localparam int DW_DEF    = 12;
  localparam int ACCW_DEF  = 25;
  localparam int LENW_DEF  = 8;
  localparam int DRAIN_CYC = 2;

  typedef logic [2:0] state_t;

  localparam state_t IDLE  = 3'd0;
  localparam state_t CLR   = 3'd1;
  localparam state_t RUN   = 3'd2;
  localparam state_t DRAIN = 3'd3;
  localparam state_t DONE  = 3'd4;

endpackage

// File: rtl/mac_dot_ctrl.sv
// rtl/mac_dot_ctrl.sv - sequences one LEN-pair dot product through an external MAC
// Optional sticky accumulator-wrap flag (ovf) when MAC_DOT_OVF_EN is defined.
module mac_dot_ctrl
  import mac_dot_pkg::*;
#(
  parameter int DW   = DW_DEF,
  parameter int ACCW = ACCW_DEF,
  parameter int LENW = LENW_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [LENW-1:0] len,
  output logic            busy,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [DW-1:0]   in_a,
  input  logic [DW-1:0]   in_b,
  output logic [DW-1:0]   mac_a,
  output logic [DW-1:0]   mac_b,
  output logic            mac_rst,
  input  logic [ACCW-1:0] mac_acc,
  output logic            res_valid,
  input  logic            res_ready,
  output logic [ACCW-1:0] res_data
`ifdef MAC_DOT_OVF_EN
  ,
  output logic            ovf
`endif
);

  localparam int DCW = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

  state_t          state, state_nx;
  logic [LENW-1:0] len_q;
  logic [LENW-1:0] cnt;
  logic [DCW-1:0]  drain_cnt;
  logic            xfer;
  logic            last_beat;

  assign busy      = (state != IDLE);
  assign in_ready  = (state == RUN) && (cnt != len_q);
  assign xfer      = in_valid & in_ready;
  assign last_beat = xfer && (cnt == len_q - 1'b1);
  assign mac_rst   = rst | (state == CLR);
  assign res_valid = (state == DONE);

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = CLR;
      CLR:     state_nx = (len_q != '0) ? RUN : DRAIN;
      RUN:     if (last_beat) state_nx = DRAIN;
      DRAIN:   if (drain_cnt == DCW'(DRAIN_CYC - 1)) state_nx = DONE;
      DONE:    if (res_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      len_q     <= '0;
      cnt       <= '0;
      drain_cnt <= '0;
      mac_a     <= '0;
      mac_b     <= '0;
      res_data  <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && start) len_q <= len;
      if (state == CLR) cnt <= '0;
      else if (xfer)    cnt <= cnt + 1'b1;
      drain_cnt <= (state == DRAIN) ? drain_cnt + 1'b1 : '0;
      // Idle cycles feed zeros so the MAC keeps adding nothing.
      mac_a <= xfer ? in_a : '0;
      mac_b <= xfer ? in_b : '0;
      if (state == DRAIN && state_nx == DONE) res_data <= mac_acc;
    end
  end

`ifdef MAC_DOT_OVF_EN
  logic [ACCW-1:0] acc_prev;

  // acc_prev is zeroed in CLR so the stale pre-clear sum cannot look like a wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf      <= 1'b0;
      acc_prev <= '0;
    end else if (state == CLR) begin
      ovf      <= 1'b0;
      acc_prev <= '0;
    end else begin
      acc_prev <= mac_acc;
      if ((state == RUN || state == DRAIN) && (mac_acc < acc_prev)) ovf <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_mac_dot_ctrl.sv
// tb/tb_mac_dot_ctrl.sv - scoreboard bench for mac_dot_ctrl with a behavioural MAC alongside
module tb_mac_dot_ctrl;
  import mac_dot_pkg::*;

  localparam int DW   = 12;
  localparam int ACCW = 25;
  localparam int LENW = 8;

  logic            clk = 1'b0;
  logic            rst, start, busy, in_valid, in_ready, mac_rst, res_valid, res_ready;
  logic [LENW-1:0] len;
  logic [DW-1:0]   in_a, in_b, mac_a, mac_b;
  logic [ACCW-1:0] mac_acc, res_data;
`ifdef MAC_DOT_OVF_EN
  logic            ovf;
  logic            last_ovf;
`endif

  int              passed = 0;
  int              total = 0;
  int              cyc_cnt = 0;
  int              start_cyc = 0;
  int              va [256];
  int              vb [256];
  logic [ACCW-1:0] exp_q[$];

  always #5 clk = ~clk;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // MAC: registered operands multiply-accumulate one edge later, wrapping mod 2**ACCW.
  always @(posedge clk) begin
    if (mac_rst) mac_acc <= '0;
    else         mac_acc <= mac_acc + ACCW'(mac_a) * ACCW'(mac_b);
  end

  mac_dot_ctrl #(.DW(DW), .ACCW(ACCW), .LENW(LENW)) dut (
    .clk(clk), .rst(rst), .start(start), .len(len), .busy(busy),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .mac_a(mac_a), .mac_b(mac_b), .mac_rst(mac_rst), .mac_acc(mac_acc),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data)
`ifdef MAC_DOT_OVF_EN
    , .ovf(ovf)
`endif
  );

  task automatic drive_job(input int n, input int mode, input int stop_after);
    longint        s = 0;
    int            idx = 0;
    int            guard = 0;
    logic          prev_x = 1'b0;
    logic          x;
    logic [DW-1:0] prev_a = '0;
    logic [DW-1:0] exp_a;
    for (int i = 0; i < n; i++) s += longint'(va[i]) * longint'(vb[i]);
    if (stop_after >= n) exp_q.push_back(ACCW'(s));
    @(posedge clk); #1;
    start = 1'b1; len = LENW'(n); start_cyc = cyc_cnt;
    @(posedge clk); #1;
    start = 1'b0;
    while (idx < n && idx < stop_after && guard < 2000) begin
      in_valid = (mode == 0) ? 1'b1 : ~guard[0];
      in_a = DW'(va[idx]);
      in_b = DW'(vb[idx]);
      @(negedge clk);
      x = in_valid & in_ready;
      exp_a = prev_x ? prev_a : '0;
      total++;
      if (mac_a !== exp_a) $display("FAIL mac_a_beat idx=%0d: got %0d expected %0d", idx, mac_a, exp_a);
      else passed++;
      @(posedge clk); #1;
      prev_x = x;
      if (x) begin prev_a = DW'(va[idx]); idx++; end
      guard++;
    end
    in_valid = 1'b0;
    if (guard >= 2000) begin
      total++;
      $display("FAIL feed_timeout: got %0d beats expected %0d", idx, n);
    end
  endtask

  task automatic wait_result(input int hold, input int chk_lat);
    int              g = 0;
    logic [ACCW-1:0] held, exp_v;
    @(negedge clk);
    while (!res_valid && g < 300) begin @(negedge clk); g++; end
    total++;
    if (!res_valid) begin
      $display("FAIL res_timeout: got res_valid=%0b expected 1", res_valid);
      return;
    end
    passed++;
    if (chk_lat >= 0) begin
      total++;
      if (cyc_cnt - start_cyc != chk_lat)
        $display("FAIL latency: got %0d expected %0d", cyc_cnt - start_cyc, chk_lat);
      else passed++;
    end
    held = res_data;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      start = (i == 2); len = 8'd5;
      @(negedge clk);
      total++;
      if (!(res_valid === 1'b1 && res_data === held))
        $display("FAIL hold_stable: got valid=%0b data=%0d expected valid=1 data=%0d", res_valid, res_data, held);
      else passed++;
    end
    @(posedge clk); #1;
    start = 1'b0; res_ready = 1'b1;
    @(negedge clk);
    total++;
    if (exp_q.size() == 0) $display("FAIL res_data: got %0d expected <empty scoreboard>", res_data);
    else begin
      exp_v = exp_q.pop_front();
      if (res_data !== exp_v) $display("FAIL res_data: got %0d expected %0d", res_data, exp_v);
      else passed++;
    end
`ifdef MAC_DOT_OVF_EN
    last_ovf = ovf;
`endif
    @(posedge clk); #1;
    res_ready = 1'b0;
    @(negedge clk);
    total++;
    if (busy !== 1'b0) $display("FAIL idle_after_handshake: got busy=%0b expected 0", busy);
    else passed++;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; len = '0; in_valid = 1'b0; in_a = '0; in_b = '0; res_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if ({busy, in_ready, res_valid, mac_rst} !== 4'b0001 || mac_a !== '0 || mac_b !== '0 || res_data !== '0)
      $display("FAIL reset_state: got busy=%0b rdy=%0b rv=%0b mrst=%0b a=%0d b=%0d d=%0d expected 0,0,0,1,0,0,0",
               busy, in_ready, res_valid, mac_rst, mac_a, mac_b, res_data);
    else passed++;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (mac_rst !== 1'b0 || busy !== 1'b0) $display("FAIL post_reset: got mac_rst=%0b busy=%0b expected 0 0", mac_rst, busy);
    else passed++;
  endtask

  task automatic test_basic();
    va[0] = 1; vb[0] = 2; va[1] = 3; vb[1] = 4; va[2] = 5; vb[2] = 6;
    drive_job(3, 0, 99);
    wait_result(0, 7);
  endtask

  task automatic test_stall();
    for (int i = 0; i < 4; i++) begin va[i] = 10; vb[i] = 10; end
    drive_job(4, 1, 99);
    wait_result(0, -1);
  endtask

  task automatic test_len0();
    exp_q.push_back('0);
    @(posedge clk); #1;
    start = 1'b1; len = '0; in_valid = 1'b1; start_cyc = cyc_cnt;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      total++;
      if (in_ready !== 1'b0) $display("FAIL len0_in_ready: got %0b expected 0", in_ready);
      else passed++;
    end
    wait_result(0, 4);
    in_valid = 1'b0;
  endtask

  task automatic test_back_to_back_hold();
    va[0] = int'($urandom_range(0, 4095)); vb[0] = int'($urandom_range(0, 4095));
    va[1] = int'($urandom_range(0, 4095)); vb[1] = int'($urandom_range(0, 4095));
    drive_job(2, 0, 99);
    wait_result(5, -1);
  endtask

  task automatic test_rst_mid();
    for (int i = 0; i < 5; i++) begin va[i] = 100 + i; vb[i] = 50 + i; end
    drive_job(5, 0, 2);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || in_ready !== 1'b0 || mac_acc !== '0)
      $display("FAIL rst_mid: got busy=%0b rdy=%0b acc=%0d expected 0 0 0", busy, in_ready, mac_acc);
    else passed++;
    va[0] = 7; vb[0] = 7;
    drive_job(1, 0, 99);
    wait_result(0, 5);
  endtask

  task automatic test_max_len();
    for (int i = 0; i < 255; i++) begin
      va[i] = int'($urandom_range(0, 4095));
      vb[i] = int'($urandom_range(0, 4095));
    end
    drive_job(255, 0, 999);
    wait_result(0, 259);
  endtask

`ifdef MAC_DOT_OVF_EN
  task automatic test_ovf();
    for (int i = 0; i < 3; i++) begin va[i] = 4095; vb[i] = 4095; end
    drive_job(3, 0, 99);
    wait_result(0, 7);
    total++;
    if (last_ovf !== 1'b1) $display("FAIL ovf_set: got %0b expected 1", last_ovf);
    else passed++;
    va[0] = 1; vb[0] = 1;
    drive_job(1, 0, 99);
    wait_result(0, 5);
    total++;
    if (last_ovf !== 1'b0) $display("FAIL ovf_clear: got %0b expected 0", last_ovf);
    else passed++;
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_len0();
    test_back_to_back_hold();
    test_rst_mid();
    test_max_len();
`ifdef MAC_DOT_OVF_EN
    test_ovf();
`endif
    total++;
    if (exp_q.size() != 0) $display("FAIL scoreboard_drain: got %0d left expected 0", exp_q.size());
    else passed++;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
